// File: rtl/pifo_calendar_cpu_initiator_if.sv
// Host request/response port and calendar CPU channel of the PIFO calendar initiator.
interface pifo_calendar_cpu_initiator_if #(
   parameter int IW = 10,
   parameter int DW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic          req_wr;
   logic [IW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic [1:0]    rsp_status;
   logic          cpu_rd_valid;
   logic [IW-1:0] cpu_rd_addr;
   logic          cpu_rd_result_valid;
   logic [DW-1:0] cpu_rd_result;
   logic          cpu_wr_valid;
   logic [IW-1:0] cpu_wr_addr;
   logic [DW-1:0] cpu_wr_data;
   logic          cpu_wr_result_valid;

   modport master (
      input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
      input  cpu_rd_result_valid, cpu_rd_result, cpu_wr_result_valid,
      output req_ready, rsp_valid, rsp_data, rsp_status,
      output cpu_rd_valid, cpu_rd_addr,
      output cpu_wr_valid, cpu_wr_addr, cpu_wr_data
   );

   modport slave (
      output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
      output cpu_rd_result_valid, cpu_rd_result, cpu_wr_result_valid,
      input  req_ready, rsp_valid, rsp_data, rsp_status,
      input  cpu_rd_valid, cpu_rd_addr,
      input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data
   );
endinterface

// File: rtl/pifo_calendar_cpu_initiator.sv
// Host-side master for the PIFO calendar CPU channel, one transaction at a time.
// Define PIFO_CPU_WR_VERIFY_EN to read back and compare every write.
module pifo_calendar_cpu_initiator #(
   parameter int PIFO_CALENDAR_SIZE        = 1024,
   parameter int PIFO_CALENDAR_INDEX_WIDTH = 10,
   parameter int PIFO_ROOT_WIDTH           = 32,
   parameter int TIMEOUT_CYCLES            = 1024
) (
   input logic clk,
   input logic rstn,
   pifo_calendar_cpu_initiator_if.master bus
);
   localparam int IW = PIFO_CALENDAR_INDEX_WIDTH;
   localparam int DW = PIFO_ROOT_WIDTH;
   localparam logic [31:0] SIZE_LIM = PIFO_CALENDAR_SIZE;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ST_OK    = 2'b00;
   localparam logic [1:0] ST_RANGE = 2'b01;
   localparam logic [1:0] ST_TMO   = 2'b10;
`ifdef PIFO_CPU_WR_VERIFY_EN
   localparam logic [1:0] ST_VFY   = 2'b11;
`endif

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RD_ISSUE  = 3'd1,
      RD_WAIT   = 3'd2,
      WR_ISSUE  = 3'd3,
      WR_WAIT   = 3'd4,
`ifdef PIFO_CPU_WR_VERIFY_EN
      VFY_ISSUE = 3'd5,
      VFY_WAIT  = 3'd6,
`endif
      RSP       = 3'd7
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [IW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [15:0]   cnt;
   logic          req_ready_q;
   logic          rsp_valid_q;
   logic [DW-1:0] rsp_data_q;
   logic [DW-1:0] rsp_data_d;
   logic [1:0]    rsp_status_q;
   logic [1:0]    rsp_status_d;
   logic          rd_valid_q;
   logic          wr_valid_q;
   logic [IW-1:0] rd_addr_q;
   logic [IW-1:0] wr_addr_q;
   logic [DW-1:0] wr_data_q;
   logic          accept;
   logic          oor;
   logic          expire;
   logic          rd_hit;
   logic          wr_hit;
   logic          rd_issue;
   logic          wr_issue;

   assign accept = bus.req_valid & req_ready_q & (state == IDLE);
   assign oor    = 32'(bus.req_addr) >= SIZE_LIM;
   assign expire = (cnt == TMO_LAST);
   assign rd_hit = bus.cpu_rd_result_valid;
   assign wr_hit = bus.cpu_wr_result_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:
            if (accept)
               state_n = oor ? RSP : (bus.req_wr ? WR_ISSUE : RD_ISSUE);
         RD_ISSUE: state_n = RD_WAIT;
         RD_WAIT:  if (rd_hit || expire) state_n = RSP;
         WR_ISSUE: state_n = WR_WAIT;
`ifdef PIFO_CPU_WR_VERIFY_EN
         WR_WAIT:
            if (wr_hit)      state_n = VFY_ISSUE;
            else if (expire) state_n = RSP;
         VFY_ISSUE: state_n = VFY_WAIT;
         VFY_WAIT:  if (rd_hit || expire) state_n = RSP;
`else
         WR_WAIT:  if (wr_hit || expire) state_n = RSP;
`endif
         RSP:      if (bus.rsp_ready) state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end

   // Response fields are loaded only on the edge that enters RSP.
   always_comb begin
      rsp_data_d   = rsp_data_q;
      rsp_status_d = rsp_status_q;
      rd_issue     = (state == RD_ISSUE);
      wr_issue     = (state == WR_ISSUE);
`ifdef PIFO_CPU_WR_VERIFY_EN
      rd_issue     = rd_issue | (state == VFY_ISSUE);
`endif
      if (state != RSP && state_n == RSP) begin
         rsp_data_d   = '0;
         rsp_status_d = ST_OK;
         unique case (state)
            IDLE: rsp_status_d = ST_RANGE;
            RD_WAIT:
               if (rd_hit) rsp_data_d   = bus.cpu_rd_result;
               else        rsp_status_d = ST_TMO;
            WR_WAIT:
               if (!wr_hit) rsp_status_d = ST_TMO;
`ifdef PIFO_CPU_WR_VERIFY_EN
            VFY_WAIT:
               if (!rd_hit) begin
                  rsp_status_d = ST_TMO;
               end else if (bus.cpu_rd_result != wdata_q) begin
                  rsp_status_d = ST_VFY;
                  rsp_data_d   = bus.cpu_rd_result;
               end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_status_q <= '0;
         rd_valid_q   <= 1'b0;
         wr_valid_q   <= 1'b0;
         rd_addr_q    <= '0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt          <= '0;
      end else begin
         req_ready_q  <= (state_n == IDLE);
         rsp_valid_q  <= (state_n == RSP);
         rsp_data_q   <= rsp_data_d;
         rsp_status_q <= rsp_status_d;
         rd_valid_q   <= rd_issue;
         wr_valid_q   <= wr_issue;
         if (rd_issue) rd_addr_q <= addr_q;
         if (wr_issue) begin
            wr_addr_q <= addr_q;
            wr_data_q <= wdata_q;
         end
         if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
         if (rd_issue || wr_issue) cnt <= '0;
         else if (!expire)         cnt <= cnt + 16'd1;
      end
   end

   assign bus.req_ready    = req_ready_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.rsp_status   = rsp_status_q;
   assign bus.cpu_rd_valid = rd_valid_q;
   assign bus.cpu_rd_addr  = rd_addr_q;
   assign bus.cpu_wr_valid = wr_valid_q;
   assign bus.cpu_wr_addr  = wr_addr_q;
   assign bus.cpu_wr_data  = wr_data_q;
endmodule

// File: tb/tb_pifo_calendar_cpu_initiator.sv
// Scoreboard bench for pifo_calendar_cpu_initiator with a behavioural calendar.
module tb_pifo_calendar_cpu_initiator;
   localparam int SIZE = 1024;
   localparam int IW   = 11;
   localparam int DW   = 32;
   localparam int TMO  = 16;
`ifdef PIFO_CPU_WR_VERIFY_EN
   localparam int VFY = 3;
`else
   localparam int VFY = 0;
`endif

   typedef struct packed {
      logic [DW-1:0] data;
      logic [1:0]    st;
   } exp_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   pifo_calendar_cpu_initiator_if #(.IW(IW), .DW(DW)) bus ();

   pifo_calendar_cpu_initiator #(
      .PIFO_CALENDAR_SIZE       (SIZE),
      .PIFO_CALENDAR_INDEX_WIDTH(IW),
      .PIFO_ROOT_WIDTH          (DW),
      .TIMEOUT_CYCLES           (TMO)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus.master)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int acc_cyc  = 0;
   exp_t sb_q[$];

   int            rd_lat = 1;
   int            wr_lat = 4;
   int            rd_cd  = 0;
   int            wr_cd  = 0;
   bit            rd_mute = 1'b0;
   bit            wr_mute = 1'b0;
   bit            inject_wr = 1'b0;
   logic [DW-1:0] rd_value = '0;
   int            rd_pulses = 0;
   int            wr_pulses = 0;
   logic [IW-1:0] last_rd_addr = '0;
   logic [IW-1:0] last_wr_addr = '0;
   logic [DW-1:0] last_wr_data = '0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   initial forever @(posedge clk) cyc++;

   // Calendar model: strobes change 1 time unit after the edge.
   initial begin
      bus.cpu_rd_result_valid = 1'b0;
      bus.cpu_rd_result       = '0;
      bus.cpu_wr_result_valid = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.cpu_rd_result_valid = 1'b0;
         bus.cpu_wr_result_valid = 1'b0;
         if (rd_cd == 1) begin
            bus.cpu_rd_result_valid = 1'b1;
            bus.cpu_rd_result       = rd_value;
         end
         if (rd_cd > 0) rd_cd--;
         if (wr_cd == 1) bus.cpu_wr_result_valid = 1'b1;
         if (wr_cd > 0) wr_cd--;
         if (inject_wr) begin
            bus.cpu_wr_result_valid = 1'b1;
            inject_wr = 1'b0;
         end
         if (bus.cpu_rd_valid) begin
            rd_pulses++;
            last_rd_addr = bus.cpu_rd_addr;
            if (!rd_mute) rd_cd = rd_lat;
         end
         if (bus.cpu_wr_valid) begin
            wr_pulses++;
            last_wr_addr = bus.cpu_wr_addr;
            last_wr_data = bus.cpu_wr_data;
            if (!wr_mute) wr_cd = wr_lat;
         end
      end
   end

   task automatic do_req(input logic wr, input logic [IW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] edata,
                         input logic [1:0] est, input bit push);
      int n;
      n = 0;
      if (push) sb_q.push_back(exp_t'({edata, est}));
      bus.req_valid = 1'b1;
      bus.req_wr    = wr;
      bus.req_addr  = a;
      bus.req_wdata = d;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) chk("accept_wait", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      acc_cyc = cyc;
   endtask

   // Latency is counted in clock edges from the accepting edge.
   task automatic get_rsp(input string tag, input int exp_lat);
      int   n;
      exp_t e;
      n = 0;
      while (!bus.rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rsp_valid) begin
         chk({tag, "_rsp_wait"}, 64'd0, 64'd1);
         return;
      end
      if (exp_lat >= 0) chk({tag, "_lat"}, 64'(cyc - acc_cyc), 64'(exp_lat));
      if (sb_q.size() == 0) begin
         chk({tag, "_sb"}, 64'd0, 64'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_data"}, 64'(bus.rsp_data), 64'(e.data));
         chk({tag, "_st"}, 64'(bus.rsp_status), 64'(e.st));
      end
      chk({tag, "_req_ready_low"}, 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int            p_rd;
      int            p_wr;
      int            bad;
      int            n;
      logic [DW-1:0] snap_d;
      logic [1:0]    snap_s;
      logic [DW-1:0] vfy_d;
      logic [1:0]    vfy_s;

      bus.req_valid = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_status", 64'(bus.rsp_status), 64'd0);
      chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
      chk("rst_cpu_valid", 64'({bus.cpu_rd_valid, bus.cpu_wr_valid}), 64'd0);
      rstn = 1'b1;
      @(negedge clk);

      rd_value = 32'h8000_1234;
      p_rd = rd_pulses;
      do_req(1'b0, 11'd5, '0, 32'h8000_1234, 2'b00, 1'b1);
      get_rsp("rd5", 3);
      chk("rd5_pulses", 64'(rd_pulses - p_rd), 64'd1);
      chk("rd5_addr", 64'(last_rd_addr), 64'd5);

      rd_value = 32'hA5A5_0001;
      p_wr = wr_pulses;
      do_req(1'b1, 11'd1023, 32'hA5A5_0001, '0, 2'b00, 1'b1);
      get_rsp("wr1023", 6 + VFY);
      chk("wr1023_pulses", 64'(wr_pulses - p_wr), 64'd1);
      chk("wr1023_addr", 64'(last_wr_addr), 64'd1023);
      chk("wr1023_wdata", 64'(last_wr_data), 64'hA5A5_0001);

      p_rd = rd_pulses;
      p_wr = wr_pulses;
      do_req(1'b0, 11'd1024, '0, '0, 2'b01, 1'b1);
      get_rsp("oor_rd", 0);
      do_req(1'b1, 11'd2047, 32'hFFFF_FFFF, '0, 2'b01, 1'b1);
      get_rsp("oor_wr", 0);
      chk("oor_pulses", 64'(rd_pulses - p_rd + wr_pulses - p_wr), 64'd0);

      wr_mute = 1'b1;
      do_req(1'b1, 11'd7, 32'h0000_1234, '0, 2'b10, 1'b1);
      get_rsp("wr_tmo", TMO + 1);
      wr_mute = 1'b0;
      repeat (4) @(negedge clk);
      inject_wr = 1'b1;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.rsp_valid) bad++;
      end
      chk("stray_ignored", 64'(bad), 64'd0);
      rd_value = 32'hCAFE_0009;
      do_req(1'b0, 11'd9, '0, 32'hCAFE_0009, 2'b00, 1'b1);
      get_rsp("after_tmo", 3);

      rd_value = 32'h0BAD_F00D;
      wr_lat = TMO - 1;
      do_req(1'b1, 11'd100, 32'h0BAD_F00D, '0, 2'b00, 1'b1);
      get_rsp("tie_wins", TMO + 1 + VFY);
      wr_lat = TMO;
      do_req(1'b1, 11'd101, 32'h0BAD_F00D, '0, 2'b10, 1'b1);
      get_rsp("late_by_one", TMO + 1);
      repeat (3) @(negedge clk);
      wr_lat = 4;

      rd_lat = 3;
      rd_value = 32'h1357_2468;
      do_req(1'b0, 11'd33, '0, 32'h1357_2468, 2'b00, 1'b1);
      inject_wr = 1'b1;
      get_rsp("wrong_type", 5);
      rd_lat = 1;

      bus.rsp_ready = 1'b0;
      rd_value = 32'h5A5A_0003;
      do_req(1'b0, 11'd3, '0, 32'h5A5A_0003, 2'b00, 1'b1);
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      snap_d = bus.rsp_data;
      snap_s = bus.rsp_status;
      p_rd = rd_pulses;
      p_wr = wr_pulses;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (!bus.rsp_valid || bus.rsp_data !== snap_d ||
             bus.rsp_status !== snap_s || bus.req_ready) bad++;
      end
      chk("hold_stable", 64'(bad), 64'd0);
      chk("hold_pulses", 64'(rd_pulses - p_rd + wr_pulses - p_wr), 64'd0);
      bus.rsp_ready = 1'b1;
      get_rsp("hold", -1);

`ifdef PIFO_CPU_WR_VERIFY_EN
      vfy_d = 32'h22;
      vfy_s = 2'b11;
`else
      vfy_d = 32'h0;
      vfy_s = 2'b00;
`endif
      rd_value = 32'h22;
      wr_lat = 2;
      p_rd = rd_pulses;
      do_req(1'b1, 11'd12, 32'h11, vfy_d, vfy_s, 1'b1);
      get_rsp("verify", 4 + VFY);
      chk("verify_rd_pulses", 64'(rd_pulses - p_rd), 64'(VFY / 3));

      rd_mute = 1'b1;
      do_req(1'b0, 11'd20, '0, '0, 2'b00, 1'b0);
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("mrst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("mrst_outputs",
          64'({bus.rsp_valid, bus.cpu_rd_valid, bus.cpu_wr_valid}), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      rd_mute = 1'b0;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.rsp_valid) bad++;
      end
      chk("mrst_no_rsp", 64'(bad), 64'd0);
      rd_value = 32'h7777_0000;
      do_req(1'b0, 11'd0, '0, 32'h7777_0000, 2'b00, 1'b1);
      get_rsp("mrst_recover", 3);

      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
